// File: rtl/vector_writeback.sv
// Vector write-back stage.
// Returns lane results to the register file one cycle after capture and,
// on request, streams the four lanes to the write-only memory (WOM) as
// four single-word writes while stalling the upstream pipeline.
//
// Memory handshake: mem_we is the valid and mem_ready is the ready. A word
// transfers on a rising edge where both are high. While mem_we=1 and
// mem_ready=0, mem_we, mem_addr and mem_wdata hold their values.
// The upstream side has no valid bit: every rising edge with stall=0 is a capture.
module vector_writeback #(
   parameter int DATA_W      = 32,
   parameter int ADDR_STRIDE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] r1,
   input  logic [DATA_W-1:0] r2,
   input  logic [DATA_W-1:0] r3,
   input  logic [DATA_W-1:0] r4,
   input  logic              wr_pxl_in,
   input  logic              wr_pos_in,
   input  logic              wr_mul_reg_in,
   input  logic              wr_mul_pos_in,
   input  logic              wr_wom_in,
   input  logic [DATA_W-1:0] wom_addr_in,
   output logic              we_pxl,
   output logic              wr_pos_pxl,
   output logic              we_mul,
   output logic              wr_mul_pos,
   output logic [DATA_W-1:0] wdp1,
   output logic [DATA_W-1:0] wdp2,
   output logic [DATA_W-1:0] wdp3,
   output logic [DATA_W-1:0] wdp4,
   output logic [DATA_W-1:0] wdm1,
   output logic [DATA_W-1:0] wdm2,
   output logic [DATA_W-1:0] wdm3,
   output logic [DATA_W-1:0] wdm4,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   output logic              stall,
   output logic [2:0]        seq_debug
);

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   localparam logic [DATA_W-1:0] STRIDE = DATA_W'(ADDR_STRIDE);

   state_t            state;
   logic [1:0]        lane;
   logic [DATA_W-1:0] base;
   logic [DATA_W-1:0] data_buf [4];
   logic              busy;
   logic [DATA_W-1:0] offset;

   assign busy   = (state == WRITE);
   assign offset = DATA_W'(lane) * STRIDE;

   assign stall     = busy;
   assign mem_we    = busy;
   assign mem_addr  = busy ? (base + offset) : '0;
   assign mem_wdata = busy ? data_buf[lane] : '0;
   assign seq_debug = {busy, lane};

   // Register write-back: refresh on every capture; write strobes drop on stalled edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_pxl     <= 1'b0;
         wr_pos_pxl <= 1'b0;
         we_mul     <= 1'b0;
         wr_mul_pos <= 1'b0;
         wdp1       <= '0;
         wdp2       <= '0;
         wdp3       <= '0;
         wdp4       <= '0;
         wdm1       <= '0;
         wdm2       <= '0;
         wdm3       <= '0;
         wdm4       <= '0;
      end else if (!busy) begin
         we_pxl     <= wr_pxl_in;
         wr_pos_pxl <= wr_pos_in;
         we_mul     <= wr_mul_reg_in;
         wr_mul_pos <= wr_mul_pos_in;
         wdp1       <= r1;
         wdp2       <= r2;
         wdp3       <= r3;
         wdp4       <= r4;
         wdm1       <= r1;
         wdm2       <= r2;
         wdm3       <= r3;
         wdm4       <= r4;
      end else begin
         we_pxl <= 1'b0;
         we_mul <= 1'b0;
      end
   end

   // WOM sequencer: latch lanes and base on a WOM capture, then step one lane per accepted word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lane  <= 2'd0;
         base  <= '0;
         for (int i = 0; i < 4; i++) begin
            data_buf[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (wr_wom_in) begin
                  state       <= WRITE;
                  lane        <= 2'd0;
                  base        <= wom_addr_in;
                  data_buf[0] <= r1;
                  data_buf[1] <= r2;
                  data_buf[2] <= r3;
                  data_buf[3] <= r4;
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  if (lane == 2'd3) begin
                     state <= IDLE;
                     lane  <= 2'd0;
                  end else begin
                     lane <= lane + 2'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               lane  <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_writeback.sv
// Randomised scoreboard bench for vector_writeback.
module tb_vector_writeback;

  localparam int DW = 32;
  localparam int STRIDE = 1;
  localparam int CW = 400;

  logic          clk;
  logic          rst;
  logic [DW-1:0] r1, r2, r3, r4;
  logic          wr_pxl_in, wr_pos_in, wr_mul_reg_in, wr_mul_pos_in, wr_wom_in;
  logic [DW-1:0] wom_addr_in;
  logic          we_pxl, wr_pos_pxl, we_mul, wr_mul_pos;
  logic [DW-1:0] wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4;
  logic          mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ready;
  logic          stall;
  logic [2:0]    seq_debug;

  vector_writeback #(.DATA_W(DW), .ADDR_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .wr_pxl_in(wr_pxl_in), .wr_pos_in(wr_pos_in), .wr_mul_reg_in(wr_mul_reg_in),
    .wr_mul_pos_in(wr_mul_pos_in), .wr_wom_in(wr_wom_in), .wom_addr_in(wom_addr_in),
    .we_pxl(we_pxl), .wr_pos_pxl(wr_pos_pxl), .we_mul(we_mul), .wr_mul_pos(wr_mul_pos),
    .wdp1(wdp1), .wdp2(wdp2), .wdp3(wdp3), .wdp4(wdp4),
    .wdm1(wdm1), .wdm2(wdm2), .wdm3(wdm3), .wdm4(wdm4),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .stall(stall), .seq_debug(seq_debug)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  localparam int RW = 4 + 8 * DW;
  logic [RW-1:0]   exp_reg_q[$];
  logic [2*DW-1:0] exp_mem_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the test
  int stall_run  = 0;
  int last_run   = 0;

  logic [CW-1:0] all_out;
  assign all_out = CW'({we_pxl, wr_pos_pxl, we_mul, wr_mul_pos,
                        wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4,
                        mem_we, mem_addr, mem_wdata, stall});

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- memory ready generator ----------------
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 0) mem_ready = 1'b1;
      else if (ready_mode == 1) mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  logic          prev_pend = 1'b0;
  logic [DW-1:0] prev_addr, prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
      stall_run = 0;
    end else begin
      // Busy exactly while expected WOM words remain outstanding.
      check("busy_flags", CW'({stall, mem_we}), CW'({2{exp_mem_q.size() != 0}}));
      if (!mem_we) check("idle_mem_zero", CW'({mem_addr, mem_wdata}), '0);
      if (prev_pend)
        check("backpressure_hold", CW'({mem_we, mem_addr, mem_wdata}),
              CW'({1'b1, prev_addr, prev_data}));
      if (mem_we && mem_ready) begin
        if (exp_mem_q.size() == 0) check("mem_unexpected", CW'({mem_addr, mem_wdata}), '1);
        else check("mem_write", CW'({mem_addr, mem_wdata}), CW'(exp_mem_q.pop_front()));
      end
      if (we_pxl || we_mul) begin
        if (exp_reg_q.size() == 0)
          check("reg_unexpected", CW'({we_pxl, we_mul}), '0);
        else
          check("reg_write", CW'({we_pxl, wr_pos_pxl, we_mul, wr_mul_pos,
                                  wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4}),
                CW'(exp_reg_q.pop_front()));
      end
      prev_pend = mem_we && !mem_ready;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
      if (stall) stall_run++;
      else if (stall_run != 0) begin
        last_run  = stall_run;
        stall_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    r1 = '0; r2 = '0; r3 = '0; r4 = '0;
    wr_pxl_in = 0; wr_pos_in = 0; wr_mul_reg_in = 0; wr_mul_pos_in = 0; wr_wom_in = 0;
    wom_addr_in = '0;
  endtask

  // Presents one transaction, holds it while stalled, and records the expected
  // effects once the capturing edge has passed.
  task automatic issue(input logic [DW-1:0] a1, a2, a3, a4,
                       input logic pxl, pos, mul, mulpos, wom,
                       input logic [DW-1:0] base);
    logic [DW-1:0] a[4];
    int guard;
    a[0] = a1; a[1] = a2; a[2] = a3; a[3] = a4;
    r1 = a1; r2 = a2; r3 = a3; r4 = a4;
    wr_pxl_in = pxl; wr_pos_in = pos; wr_mul_reg_in = mul; wr_mul_pos_in = mulpos;
    wr_wom_in = wom; wom_addr_in = base;
    guard = 0;
    while (stall && guard < 1000) begin
      idle(1);
      guard++;
    end
    if (guard >= 1000) check("issue_stall_timeout", CW'(stall), '0);
    idle(1);
    if (pxl || mul) exp_reg_q.push_back({pxl, pos, mul, mulpos, a1, a2, a3, a4, a1, a2, a3, a4});
    if (wom)
      for (int i = 0; i < 4; i++)
        exp_mem_q.push_back({base + DW'(i * STRIDE), a[i]});
    clear_inputs();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (stall && guard < 1000) begin
      idle(1);
      guard++;
    end
    if (guard >= 1000) check("wait_idle_timeout", CW'(stall), '0);
    idle(1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rst = 1'b1;
    #3;
    check("reset_async_outputs", all_out, '0);
    idle(3);
    check("reset_outputs", all_out, '0);
    rst = 1'b0;
    idle(1);

    // Pixel write with a one-cycle strobe.
    issue(1, 2, 3, 4, 1, 1, 0, 0, 0, '0);
    idle(2);

    // Mul write alone.
    issue(32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 1, 1, 0, '0);
    idle(2);

    // WOM burst with mem_ready held high: four stall cycles.
    ready_mode = 0;
    issue(32'hA, 32'hB, 32'hC, 32'hD, 0, 0, 0, 0, 1, 32'h100);
    wait_idle();
    check("burst_stall_len", CW'(last_run), CW'(4));

    // Backpressure on lane 1 for three cycles: seven stall cycles.
    ready_mode = 2;
    mem_ready  = 1'b1;
    issue(32'hA, 32'hB, 32'hC, 32'hD, 0, 0, 0, 0, 1, 32'h100);
    idle(1);
    mem_ready = 1'b0;
    idle(3);
    mem_ready = 1'b1;
    wait_idle();
    check("backpressure_stall_len", CW'(last_run), CW'(7));
    ready_mode = 0;

    // Address wrap.
    issue(32'h5, 32'h6, 32'h7, 32'h8, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    wait_idle();

    // Combined register write and WOM burst, then a mul request held during stall.
    issue(32'h21, 32'h22, 32'h23, 32'h24, 1, 0, 1, 0, 1, 32'h40);
    issue(32'h5, 32'h6, 32'h7, 32'h8, 0, 0, 1, 0, 0, '0);
    wait_idle();
    check("held_mul_captured", CW'(exp_reg_q.size()), '0);

    // Reset after lane 1 is accepted aborts the burst.
    issue(32'h31, 32'h32, 32'h33, 32'h34, 0, 0, 0, 0, 1, 32'h200);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("reset_mid_burst", all_out, '0);
    check("lanes_left_at_reset", CW'(exp_mem_q.size()), CW'(2));
    exp_mem_q.delete();
    exp_reg_q.delete();
    @(posedge clk);
    #1;
    check("reset_held_outputs", all_out, '0);
    rst = 1'b0;
    idle(8);

    // Randomised traffic with random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 80; t++) begin
      logic [DW-1:0] base;
      base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + DW'($urandom_range(0, 3))) : $urandom;
      issue($urandom, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), base);
      idle($urandom_range(0, 2));
    end
    wait_idle();
    idle(2);
    check("mem_queue_drained", CW'(exp_mem_q.size()), '0);
    check("reg_queue_drained", CW'(exp_reg_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
